// File: rtl/misc_fifo_pkg.sv
// Shared constants, writer states and helpers for the per-link misc record FIFO.
package misc_fifo_pkg;

  localparam int MISC_DATA_W        = 256;
  localparam int MISC_MAX_REC_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DISCARD
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/misc_fifo_ram.sv
// Simple dual-port record storage with a registered read port.
module misc_fifo_ram
  import misc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = MISC_DATA_W,
  parameter int DEPTH      = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/misc_link_fifo.sv
// Per-link misc record FIFO: commits whole records only, drops atomically.
module misc_link_fifo
  import misc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = MISC_DATA_W,
  parameter int DEPTH         = 512,
  parameter int MAX_REC_WORDS = MISC_MAX_REC_WORDS,
  parameter int REQ_LVL       = 16,
  parameter int AEMPTY_LVL    = 2
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iCTRL_EN,
  input  logic                    iFLUSH,
  input  logic [DATA_WIDTH-1:0]   iWR_DATA,
  input  logic                    iWR_V,
  input  logic                    iWR_SOP,
  input  logic                    iWR_EOP,
  input  logic                    iPOP,
  output logic [DATA_WIDTH-1:0]   oDATA,
  output logic                    oDATA_V,
  output logic                    oREQ,
  output logic                    oFULL,
  output logic                    oEMPTY,
  output logic                    oAEMPTY,
  output logic [$clog2(DEPTH):0]  oLEVEL,
  output logic [15:0]             oDROP_CNT,
  output logic                    oPROTO_ERR,
  output logic                    oUNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = $clog2(MAX_REC_WORDS) + 1;

  localparam logic [PW-1:0] DEP_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_P  = PW'(MAX_REC_WORDS);
  localparam logic [PW-1:0] FULL_P = PW'(DEPTH - MAX_REC_WORDS);
  localparam logic [PW-1:0] REQ_P  = PW'(REQ_LVL);
  localparam logic [PW-1:0] AE_P   = PW'(AEMPTY_LVL);
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [RW-1:0] MAX_R  = RW'(MAX_REC_WORDS);
  localparam logic [RW-1:0] ONE_R  = RW'(1);

  wr_state_e     state;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] level, occ, free;
  logic [RW-1:0] rec_cnt;
  logic [15:0]   drop_cnt;
  logic          proto_err, underflow, data_v;
  logic          space, sop_ok, over, pop_ok, we;
  logic [AW-1:0] waddr;

  // A new SOP always lands at cm_ptr: any partial record is abandoned first.
  assign level  = cm_ptr - rd_ptr;
  assign occ    = wr_ptr - rd_ptr;
  assign free   = DEP_P - level;
  assign space  = free >= MAX_P;
  assign sop_ok = iWR_V & iWR_SOP & iCTRL_EN & space;
  assign over   = rec_cnt >= MAX_R;
  assign pop_ok = iPOP & (level != '0) & ~iFLUSH;

  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr[AW-1:0];
    if (iWR_V && !iFLUSH) begin
      if (iWR_SOP) begin
        we    = sop_ok;
        waddr = cm_ptr[AW-1:0];
      end else if (state == ST_ACCEPT) begin
        we = !over;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      rec_cnt   <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
      underflow <= 1'b0;
      data_v    <= 1'b0;
    end else if (iFLUSH) begin
      state     <= (state == ST_ACCEPT) ? ST_DISCARD : ST_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      rec_cnt   <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
      underflow <= 1'b0;
      data_v    <= 1'b0;
    end else begin
      data_v <= pop_ok;
      if (pop_ok) rd_ptr <= rd_ptr + ONE_P;
      if (iPOP && level == '0) underflow <= 1'b1;
      if (iWR_V && iWR_SOP) begin
        if (state != ST_IDLE) proto_err <= 1'b1;
        if (sop_ok) begin
          wr_ptr  <= cm_ptr + ONE_P;
          rec_cnt <= ONE_R;
          if (iWR_EOP) cm_ptr <= cm_ptr + ONE_P;
          state <= iWR_EOP ? ST_IDLE : ST_ACCEPT;
        end else begin
          wr_ptr <= cm_ptr;
          if (iCTRL_EN) drop_cnt <= sat_inc16(drop_cnt);
          state <= iWR_EOP ? ST_IDLE : ST_DISCARD;
        end
      end else if (iWR_V) begin
        unique case (state)
          ST_IDLE: proto_err <= 1'b1;
          ST_ACCEPT: begin
            if (over) begin
              wr_ptr   <= cm_ptr;
              drop_cnt <= sat_inc16(drop_cnt);
              state    <= iWR_EOP ? ST_IDLE : ST_DISCARD;
            end else begin
              wr_ptr  <= wr_ptr + ONE_P;
              rec_cnt <= rec_cnt + ONE_R;
              if (iWR_EOP) begin
                cm_ptr <= wr_ptr + ONE_P;
                state  <= ST_IDLE;
              end
            end
          end
          ST_DISCARD: if (iWR_EOP) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  misc_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (iCLK),
    .rst_n(iRST_N),
    .we   (we),
    .waddr(waddr),
    .wdata(iWR_DATA),
    .re   (pop_ok),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(oDATA)
  );

  assign oDATA_V    = data_v;
  assign oLEVEL     = level;
  assign oREQ       = iCTRL_EN & (level >= REQ_P);
  assign oFULL      = occ > FULL_P;
  assign oEMPTY     = level == '0;
  assign oAEMPTY    = level <= AE_P;
  assign oDROP_CNT  = drop_cnt;
  assign oPROTO_ERR = proto_err;
  assign oUNDERFLOW = underflow;

endmodule
